// File: rtl/instr_encoder_if.sv
// ============================================================================
// Module   : instr_encoder_if
// Brief    : Field-bundle stream and instruction-memory write port of instr_encoder.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface instr_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [2:0]        in_fa;
  logic [2:0]        in_fb;
  logic              in_last;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [8:0]        im_wdata;
  logic [ADDR_W:0]   word_count;
  logic              done;
  logic              error;
  logic [1:0]        err_code;

  modport master (
    output start, in_valid, in_op, in_fa, in_fb, in_last,
    input  in_ready, im_we, im_addr, im_wdata, word_count, done, error, err_code
  );

  modport slave (
    input  start, in_valid, in_op, in_fa, in_fb, in_last,
    output in_ready, im_we, im_addr, im_wdata, word_count, done, error, err_code
  );
endinterface

`default_nettype wire

// File: rtl/instr_encoder.sv
// ============================================================================
// Module   : instr_encoder
// Brief    : Packs {op,fa,fb} bundles into 9-bit words and writes them into
//            instruction memory sequentially from address 0.
// Revision : 1.0
// ============================================================================
`default_nettype none

module instr_encoder #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  instr_encoder_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] c_depth     = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] c_last_addr = c_depth - {{ADDR_W{1'b0}}, 1'b1};

  state_t            r_state;
  logic              r_we;
  logic              r_last;
  logic [ADDR_W-1:0] r_addr;
  logic [8:0]        r_wdata;
  logic [ADDR_W:0]   r_count;
  logic              r_done;
  logic              r_error;
  logic [1:0]        r_err_code;

  logic              w_stop;
  logic              w_ready;
  logic              w_xfer;
  logic              w_illegal;
  logic              w_we;
  logic [ADDR_W:0]   w_cnt_nxt;

  // A word in its write cycle that ends the load (last or final address) blocks new bundles.
  assign w_stop    = r_we && (r_last || ({1'b0, r_addr} == c_last_addr));
  assign w_ready   = (r_state == S_RUN) && !bus.start && (r_count < c_depth) && !w_stop;
  assign w_xfer    = bus.in_valid && w_ready;
  assign w_illegal = ((bus.in_op == 3'b100) || (bus.in_op == 3'b101)) && (bus.in_fb == 3'd0);
  // A restart in the write cycle drops that write.
  assign w_we      = r_we && !bus.start;
  assign w_cnt_nxt = r_count + {{ADDR_W{1'b0}}, w_we};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_we       <= 1'b0;
      r_last     <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_count    <= '0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_err_code <= 2'b00;
    end else begin
      r_we <= 1'b0;
      if (bus.start) begin
        r_state    <= S_RUN;
        r_count    <= '0;
        r_done     <= 1'b0;
        r_error    <= 1'b0;
        r_err_code <= 2'b00;
      end else begin
        if (w_we) begin
          r_count <= w_cnt_nxt;
          if (r_last) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else if ({1'b0, r_addr} == c_last_addr) begin
            r_state    <= S_ERR;
            r_error    <= 1'b1;
            r_err_code <= 2'b10;
          end
        end
        if (w_xfer) begin
          if (w_illegal) begin
            r_state    <= S_ERR;
            r_error    <= 1'b1;
            r_err_code <= 2'b01;
          end else begin
            r_we    <= 1'b1;
            r_last  <= bus.in_last;
            r_addr  <= w_cnt_nxt[ADDR_W-1:0];
            r_wdata <= {bus.in_op, bus.in_fa, bus.in_fb};
          end
        end
      end
    end
  end

  assign bus.in_ready   = w_ready;
  assign bus.im_we      = w_we;
  assign bus.im_addr    = r_addr;
  assign bus.im_wdata   = r_wdata;
  assign bus.word_count = r_count;
  assign bus.done       = r_done;
  assign bus.error      = r_error;
  assign bus.err_code   = r_err_code;

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// ============================================================================
// Module   : tb_instr_encoder
// Brief    : Self-checking bench for instr_encoder (DEPTH=256 and DEPTH=4 instances).
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_instr_encoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start = 1'b0, in_valid = 1'b0, in_last = 1'b0, sel = 1'b0;
  logic [2:0] in_op = 3'd0, in_fa = 3'd0, in_fb = 3'd0;

  instr_encoder_if #(.ADDR_W(8)) b0 ();
  instr_encoder_if #(.ADDR_W(3)) b1 ();

  assign b0.start = start;  assign b0.in_valid = in_valid; assign b0.in_last = in_last;
  assign b0.in_op = in_op;  assign b0.in_fa = in_fa;       assign b0.in_fb = in_fb;
  assign b1.start = start;  assign b1.in_valid = in_valid; assign b1.in_last = in_last;
  assign b1.in_op = in_op;  assign b1.in_fa = in_fa;       assign b1.in_fb = in_fb;

  instr_encoder #(.ADDR_W(8), .DEPTH(256)) dut  (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  instr_encoder #(.ADDR_W(3), .DEPTH(4))   dut4 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

  logic       m_ready, m_we, m_done, m_error;
  logic [7:0] m_addr;
  logic [8:0] m_wdata, m_count;
  logic [1:0] m_err;

  always_comb begin
    if (sel) begin
      m_ready = b1.in_ready; m_we = b1.im_we; m_done = b1.done; m_error = b1.error;
      m_addr = {5'd0, b1.im_addr}; m_wdata = b1.im_wdata; m_count = {5'd0, b1.word_count};
      m_err = b1.err_code;
    end else begin
      m_ready = b0.in_ready; m_we = b0.im_we; m_done = b0.done; m_error = b0.error;
      m_addr = b0.im_addr; m_wdata = b0.im_wdata; m_count = b0.word_count;
      m_err = b0.err_code;
    end
  end

  typedef struct {
    logic [7:0] addr;
    logic [8:0] data;
    int         cyc;
  } wr_t;

  wr_t        wq[$];
  logic [8:0] exp_q[$];
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;

  always @(posedge clk) cyc++;
  always @(negedge clk) if (m_we === 1'b1) wq.push_back('{m_addr, m_wdata, cyc});

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
    wq.delete(); exp_q.delete();
  endtask

  task automatic send(input logic [2:0] op, input logic [2:0] fa, input logic [2:0] fb,
                      input logic last, input int budget, output logic acc);
    in_op = op; in_fa = fa; in_fb = fb; in_last = last; in_valid = 1'b1; acc = 1'b0;
    for (int i = 0; i < budget && !acc; i++) begin
      @(negedge clk);
      if (m_ready === 1'b1) acc = 1'b1;
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Random legal bundle: shifts never by zero.
  task automatic rand_bundle(output logic [2:0] op, output logic [2:0] fa, output logic [2:0] fb);
    op = 3'($urandom_range(0, 7));
    fa = 3'($urandom_range(0, 7));
    fb = (op == 3'b100 || op == 3'b101) ? 3'($urandom_range(1, 7)) : 3'($urandom_range(0, 7));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    for (int s = 0; s < 2; s++) begin
      sel = s[0]; #1;
      checks++; if (m_ready !== 1'b0) begin errors++; $display("FAIL reset_ready[%0d]: got %b want 0", s, m_ready); end
      checks++; if (m_we !== 1'b0) begin errors++; $display("FAIL reset_we[%0d]: got %b want 0", s, m_we); end
      checks++; if (m_done !== 1'b0 || m_error !== 1'b0) begin errors++; $display("FAIL reset_flags[%0d]: got done=%b error=%b want 0/0", s, m_done, m_error); end
      checks++; if (m_addr !== 8'd0 || m_wdata !== 9'd0) begin errors++; $display("FAIL reset_bus[%0d]: got addr=%0d wdata=%b want 0/0", s, m_addr, m_wdata); end
      checks++; if (m_count !== 9'd0 || m_err !== 2'b00) begin errors++; $display("FAIL reset_count[%0d]: got count=%0d err=%b want 0/00", s, m_count, m_err); end
    end
    sel = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    tick(); @(negedge clk);
    checks++; if (m_ready !== 1'b0) begin errors++; $display("FAIL idle_ready: got %b want 0", m_ready); end
  endtask

  task automatic test_single_add();
    logic acc;
    sel = 1'b0; tick(); pulse_start();
    send(3'b001, 3'd2, 3'd5, 1'b1, 4, acc);
    checks++; if (acc !== 1'b1) begin errors++; $display("FAIL single_accept: got %b want 1", acc); end
    @(negedge clk);
    checks++; if (m_we !== 1'b1 || m_addr !== 8'd0 || m_wdata !== 9'b001_010_101) begin
      errors++; $display("FAIL single_write: got we=%b addr=%0d wdata=%b want 1/0/001010101", m_we, m_addr, m_wdata); end
    tick(); @(negedge clk);
    checks++; if (m_done !== 1'b1 || m_error !== 1'b0 || m_count !== 9'd1) begin
      errors++; $display("FAIL single_done: got done=%b error=%b count=%0d want 1/0/1", m_done, m_error, m_count); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic acc;
    logic [2:0] ops [4] = '{3'b000, 3'b010, 3'b011, 3'b111};
    logic [2:0] fa, fb;
    sel = 1'b0; pulse_start();
    for (int i = 0; i < 4; i++) begin
      fa = 3'($urandom_range(0, 7)); fb = 3'($urandom_range(0, 7));
      exp_q.push_back({ops[i], fa, fb});
      send(ops[i], fa, fb, i == 3, 1, acc);
      checks++; if (acc !== 1'b1) begin errors++; $display("FAIL b2b_accept[%0d]: got %b want 1", i, acc); end
    end
    repeat (3) tick();
    checks++; if (wq.size() != 4) begin errors++; $display("FAIL b2b_count: got %0d writes want 4", wq.size()); end
    for (int i = 0; i < wq.size() && i < 4; i++) begin
      checks++; if (wq[i].addr !== 8'(i) || wq[i].data !== exp_q[i]) begin
        errors++; $display("FAIL b2b_word[%0d]: got addr=%0d data=%b want %0d/%b", i, wq[i].addr, wq[i].data, i, exp_q[i]); end
      if (i > 0) begin
        checks++; if (wq[i].cyc != wq[i-1].cyc + 1) begin
          errors++; $display("FAIL b2b_gap[%0d]: got cycle %0d want %0d", i, wq[i].cyc, wq[i-1].cyc + 1); end
      end
    end
    @(negedge clk);
    checks++; if (m_done !== 1'b1 || m_count !== 9'd4) begin
      errors++; $display("FAIL b2b_done: got done=%b count=%0d want 1/4", m_done, m_count); end
    tick();
  endtask

  task automatic test_illegal();
    logic acc;
    logic [2:0] op;
    sel = 1'b0;
    for (int t = 0; t < 2; t++) begin
      op = (t == 0) ? 3'b100 : 3'b101;
      pulse_start();
      send(op, 3'($urandom_range(0, 7)), 3'd0, 1'($urandom_range(0, 1)), 4, acc);
      checks++; if (acc !== 1'b1) begin errors++; $display("FAIL illegal_accept[%0d]: got %b want 1", t, acc); end
      @(negedge clk);
      checks++; if (m_we !== 1'b0 || m_error !== 1'b1 || m_err !== 2'b01 || m_ready !== 1'b0 || m_done !== 1'b0) begin
        errors++; $display("FAIL illegal_state[%0d]: got we=%b error=%b err=%b ready=%b done=%b want 0/1/01/0/0",
                           t, m_we, m_error, m_err, m_ready, m_done); end
      tick();
      checks++; if (wq.size() != 0) begin errors++; $display("FAIL illegal_nowrite[%0d]: got %0d writes want 0", t, wq.size()); end
      pulse_start(); @(negedge clk);
      checks++; if (m_count !== 9'd0 || m_error !== 1'b0 || m_err !== 2'b00 || m_ready !== 1'b1) begin
        errors++; $display("FAIL illegal_restart[%0d]: got count=%0d error=%b err=%b ready=%b want 0/0/00/1",
                           t, m_count, m_error, m_err, m_ready); end
      tick();
    end
  endtask

  task automatic test_overflow();
    logic acc;
    logic [2:0] op, fa, fb;
    sel = 1'b1;
    for (int rep = 0; rep < 2; rep++) begin
      pulse_start();
      for (int i = 0; i < 5; i++) begin
        if (rep == 1 && i == 4) break;
        rand_bundle(op, fa, fb);
        send(op, fa, fb, rep == 1 && i == 3, 6, acc);
        if (acc) exp_q.push_back({op, fa, fb});
        checks++; if (acc !== (i < 4)) begin
          errors++; $display("FAIL ovf_accept[%0d.%0d]: got %b want %b", rep, i, acc, i < 4); end
      end
      repeat (2) tick();
      checks++; if (wq.size() != 4) begin errors++; $display("FAIL ovf_writes[%0d]: got %0d want 4", rep, wq.size()); end
      for (int i = 0; i < wq.size() && i < exp_q.size(); i++) begin
        checks++; if (wq[i].addr !== 8'(i) || wq[i].data !== exp_q[i]) begin
          errors++; $display("FAIL ovf_word[%0d.%0d]: got addr=%0d data=%b want %0d/%b", rep, i, wq[i].addr, wq[i].data, i, exp_q[i]); end
      end
      @(negedge clk);
      checks++; if (m_count !== 9'd4 || m_ready !== 1'b0) begin
        errors++; $display("FAIL ovf_count[%0d]: got count=%0d ready=%b want 4/0", rep, m_count, m_ready); end
      checks++; if (m_done !== (rep == 1) || m_error !== (rep == 0) || m_err !== ((rep == 0) ? 2'b10 : 2'b00)) begin
        errors++; $display("FAIL ovf_flags[%0d]: got done=%b error=%b err=%b want %b/%b/%b",
                           rep, m_done, m_error, m_err, rep == 1, rep == 0, (rep == 0) ? 2'b10 : 2'b00); end
      tick();
    end
    sel = 1'b0;
  endtask

  task automatic test_reset_midload();
    logic acc;
    logic [2:0] op, fa, fb;
    sel = 1'b0; pulse_start();
    rand_bundle(op, fa, fb);
    send(op, fa, fb, 1'b0, 4, acc);
    checks++; if (acc !== 1'b1 || m_we !== 1'b1) begin
      errors++; $display("FAIL midrst_inflight: got acc=%b we=%b want 1/1", acc, m_we); end
    rst_n = 1'b0; #1;
    checks++; if (m_we !== 1'b0 || m_count !== 9'd0 || m_addr !== 8'd0 || m_wdata !== 9'd0) begin
      errors++; $display("FAIL midrst_bus: got we=%b count=%0d addr=%0d wdata=%b want 0/0/0/0", m_we, m_count, m_addr, m_wdata); end
    checks++; if (m_ready !== 1'b0 || m_done !== 1'b0 || m_error !== 1'b0 || m_err !== 2'b00) begin
      errors++; $display("FAIL midrst_flags: got ready=%b done=%b error=%b err=%b want 0/0/0/00", m_ready, m_done, m_error, m_err); end
    tick(); rst_n = 1'b1; tick(); @(negedge clk);
    checks++; if (m_ready !== 1'b0 || wq.size() != 0) begin
      errors++; $display("FAIL midrst_idle: got ready=%b writes=%0d want 0/0", m_ready, wq.size()); end
    tick();
  endtask

  task automatic test_restart_gaps();
    logic acc;
    logic [2:0] op, fa, fb;
    int k, m;
    sel = 1'b0; pulse_start();
    k = $urandom_range(3, 6);
    for (int i = 0; i < k; i++) begin
      rand_bundle(op, fa, fb);
      repeat ($urandom_range(0, 2)) tick();
      send(op, fa, fb, 1'b0, 4, acc);
      if (i < k - 1) exp_q.push_back({op, fa, fb});
      checks++; if (acc !== 1'b1) begin errors++; $display("FAIL rs_accept1[%0d]: got %b want 1", i, acc); end
    end
    // Restart lands in the write cycle of the k-th word, so that word is dropped.
    start = 1'b1; tick(); start = 1'b0;
    @(negedge clk);
    checks++; if (wq.size() != k - 1 || m_count !== 9'd0) begin
      errors++; $display("FAIL rs_seg1: got writes=%0d count=%0d want %0d/0", wq.size(), m_count, k - 1); end
    for (int i = 0; i < wq.size() && i < exp_q.size(); i++) begin
      checks++; if (wq[i].addr !== 8'(i) || wq[i].data !== exp_q[i]) begin
        errors++; $display("FAIL rs_word1[%0d]: got addr=%0d data=%b want %0d/%b", i, wq[i].addr, wq[i].data, i, exp_q[i]); end
    end
    wq.delete(); exp_q.delete();
    tick();
    m = $urandom_range(2, 6);
    for (int i = 0; i < m; i++) begin
      rand_bundle(op, fa, fb);
      repeat ($urandom_range(0, 2)) tick();
      send(op, fa, fb, i == m - 1, 4, acc);
      exp_q.push_back({op, fa, fb});
      checks++; if (acc !== 1'b1) begin errors++; $display("FAIL rs_accept2[%0d]: got %b want 1", i, acc); end
    end
    repeat (3) tick();
    checks++; if (wq.size() != m) begin errors++; $display("FAIL rs_seg2: got writes=%0d want %0d", wq.size(), m); end
    for (int i = 0; i < wq.size() && i < exp_q.size(); i++) begin
      checks++; if (wq[i].addr !== 8'(i) || wq[i].data !== exp_q[i]) begin
        errors++; $display("FAIL rs_word2[%0d]: got addr=%0d data=%b want %0d/%b", i, wq[i].addr, wq[i].data, i, exp_q[i]); end
    end
    @(negedge clk);
    checks++; if (m_done !== 1'b1 || m_count !== 9'(m)) begin
      errors++; $display("FAIL rs_done: got done=%b count=%0d want 1/%0d", m_done, m_count, m); end
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_add();
    test_back_to_back();
    test_illegal();
    test_overflow();
    test_reset_midload();
    for (int r = 0; r < 3; r++) test_restart_gaps();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
